// File: rtl/dma_engine.sv
// Word-copy DMA engine: a CPU-programmed register port plus a bus initiator
// that copies CNT words SRC->DST. Define DMA_FILL_EN to add constant-fill mode.
module dma_engine #(
   parameter int          CNT_W     = 8,
   parameter logic [31:0] ADDR_STEP = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  A,
   input  logic        WE,
   input  logic [31:0] WD,
   output logic [31:0] RD,
   output logic        Done,
   output logic        m_req,
   input  logic        m_gnt,
   output logic [31:0] m_addr,
   output logic        m_we,
   output logic [31:0] m_wd,
   input  logic [31:0] m_rd
);

   typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} state_t;

   // Handshake: while m_req is high the engine holds m_addr/m_wd steady and
   // a transfer (read capture or write) completes only on an edge with m_gnt=1.

   state_t           state;
   logic [31:0]      src;
   logic [31:0]      dst;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      data_buf;
   logic             done;
   logic             fill;
   logic             busy;
   logic             start;
   logic             fill_req;

   assign busy  = (state != ST_IDLE);
   assign start = WE && (A == 2'd3) && WD[0] && !busy;

`ifdef DMA_FILL_EN
   assign fill_req = WD[1];
`else
   assign fill_req = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         src      <= '0;
         dst      <= '0;
         cnt      <= '0;
         data_buf <= '0;
         done     <= 1'b0;
         fill     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  fill <= fill_req;
                  // A zero-length transfer completes immediately without touching the bus.
                  if (cnt == '0) begin
                     done <= 1'b1;
                  end else begin
                     done  <= 1'b0;
                     state <= fill_req ? ST_WR : ST_RD;
                  end
               end else if (WE) begin
                  case (A)
                     2'd0:    src <= WD;
                     2'd1:    dst <= WD;
                     2'd2:    cnt <= WD[CNT_W-1:0];
                     default: ;
                  endcase
               end
            end
            ST_RD: begin
               if (m_gnt) begin
                  data_buf <= m_rd;
                  state    <= ST_WR;
               end
            end
            ST_WR: begin
               if (m_gnt) begin
                  dst <= dst + ADDR_STEP;
                  cnt <= cnt - CNT_W'(1);
                  if (!fill) src <= src + ADDR_STEP;
                  if (cnt == CNT_W'(1)) begin
                     done  <= 1'b1;
                     state <= ST_IDLE;
                  end else begin
                     state <= fill ? ST_WR : ST_RD;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      m_req  = busy;
      m_we   = (state == ST_WR) && m_gnt;
      m_addr = '0;
      m_wd   = '0;
      case (state)
         ST_RD: m_addr = src;
         ST_WR: begin
            m_addr = dst;
            m_wd   = fill ? src : data_buf;
         end
         default: ;
      endcase
   end

   always_comb begin
      RD = '0;
      case (A)
         2'd0: RD = src;
         2'd1: RD = dst;
         2'd2: RD[CNT_W-1:0] = cnt;
         default: begin
            RD[1:0] = {busy, done};
`ifdef DMA_FILL_EN
            RD[2] = fill;
`endif
         end
      endcase
   end

   assign Done = done;

endmodule

// File: tb/tb_dma_engine.sv
// Directed self-checking bench for dma_engine: copy, zero count, grant stall,
// busy protection, address wrap, async reset, and fill mode under DMA_FILL_EN.
module tb_dma_engine;

   localparam int W = 80;

   logic        clk;
   logic        rst;
   logic [1:0]  A;
   logic        WE;
   logic [31:0] WD;
   logic [31:0] RD;
   logic        Done;
   logic        m_req;
   logic        m_gnt;
   logic [31:0] m_addr;
   logic        m_we;
   logic [31:0] m_wd;
   logic [31:0] m_rd;

   logic [31:0] mem [0:63];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];
   int cyc;
   int req_seen;
   int rd_seen;
   int passed;
   int total;
   int start_cyc;
   int done_cyc;
   logic [31:0] rv;

   dma_engine dut (
      .clk(clk), .rst(rst), .A(A), .WE(WE), .WD(WD), .RD(RD), .Done(Done),
      .m_req(m_req), .m_gnt(m_gnt), .m_addr(m_addr), .m_we(m_we),
      .m_wd(m_wd), .m_rd(m_rd)
   );

   assign m_rd = mem[m_addr[7:2]];

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // bus monitor: log every committed write with the edge index it lands on
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (m_req) req_seen = req_seen + 1;
      if (m_req && m_gnt && !m_we) rd_seen = rd_seen + 1;
      if (m_we) got_q.push_back({16'(cyc), m_addr, m_wd});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // driver tasks (called at a negedge, return at a negedge)
   task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
      A = a; WE = 1'b1; WD = d;
      @(negedge clk);
      WE = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
      A = a;
      #1 d = RD;
   endtask

   task automatic expect_wr(input int off, input logic [31:0] addr, input logic [31:0] data);
      exp_q.push_back({16'(start_cyc + off), addr, data});
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 200 && !Done; i++) @(negedge clk);
      done_cyc = cyc;
      chk(tag, {31'b0, Done}, 32'd1);
   endtask

   task automatic sb_check(input string tag);
      logic [W-1:0] g;
      logic [W-1:0] e;
      chk({tag, "_nwr"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         chk({tag, "_cyc"}, {16'b0, g[79:64]}, {16'b0, e[79:64]});
         chk({tag, "_addr"}, g[63:32], e[63:32]);
         chk({tag, "_data"}, g[31:0], e[31:0]);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      cyc = 0; req_seen = 0; rd_seen = 0; passed = 0; total = 0;
      start_cyc = 0; done_cyc = 0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + i;
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
      mem[4] = 32'hAA; mem[5] = 32'hBB;
      mem[8] = 32'h01; mem[9] = 32'h02; mem[10] = 32'h03;
      mem[63] = 32'h77;
      rst = 1'b1; A = 2'd0; WE = 1'b0; WD = '0; m_gnt = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // reset state
      chk("rst_mreq", {31'b0, m_req}, 32'd0);
      chk("rst_done", {31'b0, Done}, 32'd0);
      chk("rst_maddr", m_addr, 32'd0);
      for (int a = 0; a < 4; a++) begin
         cfg_read(2'(a), rv);
         chk($sformatf("rst_reg%0d", a), rv, 32'd0);
      end

      // CNT register is CNT_W bits, zero-extended on read
      cfg_write(2'd2, 32'h1FF);
      cfg_read(2'd2, rv);
      chk("cnt_zext", rv, 32'h0FF);
      cfg_write(2'd2, 32'h0);

      // zero-length transfer
      chk("cnt0_pre_done", {31'b0, Done}, 32'd0);
      req_seen = 0;
      cfg_write(2'd3, 32'h1);
      chk("cnt0_done", {31'b0, Done}, 32'd1);
      repeat (4) @(negedge clk);
      chk("cnt0_noreq", req_seen, 0);
      chk("cnt0_nowr", got_q.size(), 0);

      // copy 3 words
      cfg_write(2'd0, 32'h00);
      cfg_write(2'd1, 32'h40);
      cfg_write(2'd2, 32'd3);
      cfg_write(2'd3, 32'h1);
      chk("copy_done_clr", {31'b0, Done}, 32'd0);
      cfg_read(2'd3, rv);
      chk("copy_busy", rv, 32'h2);
      expect_wr(2, 32'h40, 32'h11);
      expect_wr(4, 32'h44, 32'h22);
      expect_wr(6, 32'h48, 32'h33);
      wait_done("copy_done");
      chk("copy_done_cyc", done_cyc - start_cyc, 6);
      sb_check("copy");
      cfg_read(2'd3, rv); chk("copy_status", rv, 32'h1);
      cfg_read(2'd0, rv); chk("copy_src", rv, 32'h0C);
      cfg_read(2'd1, rv); chk("copy_dst", rv, 32'h4C);
      cfg_read(2'd2, rv); chk("copy_cnt", rv, 32'h0);

      // grant dropped for 5 cycles in the first WR
      cfg_write(2'd0, 32'h10);
      cfg_write(2'd1, 32'h80);
      cfg_write(2'd2, 32'd2);
      cfg_write(2'd3, 32'h1);
      @(negedge clk);
      m_gnt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("stall_we%0d", i), {31'b0, m_we}, 32'd0);
         chk($sformatf("stall_addr%0d", i), m_addr, 32'h80);
         @(negedge clk);
      end
      m_gnt = 1'b1;
      expect_wr(7, 32'h80, 32'hAA);
      expect_wr(9, 32'h84, 32'hBB);
      wait_done("stall_done");
      chk("stall_done_cyc", done_cyc - start_cyc, 9);
      sb_check("stall");

      // writes and START while busy are ignored
      cfg_write(2'd0, 32'h20);
      cfg_write(2'd1, 32'hC0);
      cfg_write(2'd2, 32'd3);
      cfg_write(2'd3, 32'h1);
      expect_wr(2, 32'hC0, 32'h01);
      expect_wr(4, 32'hC4, 32'h02);
      expect_wr(6, 32'hC8, 32'h03);
      A = 2'd0; WE = 1'b1; WD = 32'h80;
      @(negedge clk);
      A = 2'd3; WD = 32'h1;
      @(negedge clk);
      WE = 1'b0;
      wait_done("busy_done");
      repeat (6) @(negedge clk);
      sb_check("busy");
      cfg_read(2'd0, rv); chk("busy_src", rv, 32'h2C);

      // 32-bit address wrap-around
      cfg_write(2'd0, 32'hFFFF_FFFC);
      cfg_write(2'd1, 32'hFFFF_FFFC);
      cfg_write(2'd2, 32'd2);
      cfg_write(2'd3, 32'h1);
      expect_wr(2, 32'hFFFF_FFFC, 32'h77);
      expect_wr(4, 32'h0, 32'h11);
      wait_done("wrap_done");
      sb_check("wrap");
      cfg_read(2'd0, rv); chk("wrap_src", rv, 32'h4);
      cfg_read(2'd1, rv); chk("wrap_dst", rv, 32'h4);

`ifdef DMA_FILL_EN
      // constant fill, one word per cycle, no reads
      cfg_write(2'd0, 32'hA5A5_A5A5);
      cfg_write(2'd1, 32'h40);
      cfg_write(2'd2, 32'd4);
      rd_seen = 0;
      cfg_write(2'd3, 32'h3);
      for (int i = 0; i < 4; i++) expect_wr(i + 1, 32'h40 + 32'(4 * i), 32'hA5A5_A5A5);
      wait_done("fill_done");
      sb_check("fill");
      chk("fill_noread", rd_seen, 0);
      cfg_read(2'd3, rv); chk("fill_status", rv, 32'h5);
      cfg_read(2'd0, rv); chk("fill_src", rv, 32'hA5A5_A5A5);
`endif

      // async reset in WR
      cfg_write(2'd0, 32'h0);
      cfg_write(2'd1, 32'h40);
      cfg_write(2'd2, 32'd3);
      cfg_write(2'd3, 32'h1);
      @(negedge clk);
      chk("arst_in_wr", {31'b0, m_we}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_mreq", {31'b0, m_req}, 32'd0);
      chk("arst_mwe", {31'b0, m_we}, 32'd0);
      chk("arst_done", {31'b0, Done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      got_q.delete();
      for (int a = 0; a < 4; a++) begin
         cfg_read(2'(a), rv);
         chk($sformatf("arst_reg%0d", a), rv, 32'd0);
      end
      repeat (4) @(negedge clk);
      chk("arst_nowr", got_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
